// File: rtl/decoder_pkg.sv
// Shared mode encodings and one-hot helper for the sequential one-hot decoder.
package decoder_pkg;

  typedef enum logic [1:0] {
    MODE_DEC  = 2'b00,
    MODE_UP   = 2'b01,
    MODE_DN   = 2'b10,
    MODE_HOLD = 2'b11
  } mode_e;

  // Widest select supported by onehot(); callers truncate to their own OUT_W.
  localparam int MAX_SEL_W  = 6;
  localparam int ONEHOT_MAX = 2 ** MAX_SEL_W;

  function automatic logic [ONEHOT_MAX-1:0] onehot(input logic [MAX_SEL_W-1:0] idx);
    logic [ONEHOT_MAX-1:0] r;
    r      = '0;
    r[idx] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/onehot_decoder_seq_if.sv
// Control, select and one-hot output bundle of the sequential one-hot decoder.
interface onehot_decoder_seq_if
  import decoder_pkg::*;
#(
  parameter int SEL_W   = 2,
  parameter int DWELL_W = 4
);
  localparam int OUT_W = 2 ** SEL_W;

  logic [1:0]         mode;
  logic               en;
  logic               in_valid;
  logic               in_ready;
  logic [SEL_W-1:0]   I;
  logic [DWELL_W-1:0] dwell;
  logic [OUT_W-1:0]   D;
  logic [SEL_W-1:0]   idx;
  logic               out_valid;
  logic               wrap;

  modport master (
    output mode, en, in_valid, I, dwell,
    input  in_ready, D, idx, out_valid, wrap
  );

  modport slave (
    input  mode, en, in_valid, I, dwell,
    output in_ready, D, idx, out_valid, wrap
  );

endinterface

// File: rtl/dwell_timer.sv
// Dwell counter: counts while run is high and pulses tc when count equals dwell.
module dwell_timer #(
  parameter int DWELL_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               restart,
  input  logic               run,
  input  logic [DWELL_W-1:0] dwell,
  output logic               tc
);

  logic [DWELL_W-1:0] count_q;
  logic [DWELL_W-1:0] base;

  // A restart makes this cycle's compare behave as if the count were already 0.
  assign base = restart ? '0 : count_q;
  assign tc   = run & (base == dwell);

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments keep every register updating from pre-edge values.
    if (rst) begin
      count_q <= '0;
    end else if (run) begin
      count_q <= tc ? '0 : base + DWELL_W'(1);
    end else if (restart) begin
      count_q <= '0;
    end
  end

endmodule

// File: rtl/onehot_decoder_seq.sv
// Registered binary-to-one-hot decoder with valid/ready load, output enable
// and up/down auto-scan at a programmable dwell rate.
module onehot_decoder_seq
  import decoder_pkg::*;
#(
  parameter int SEL_W   = 2,
  parameter int DWELL_W = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  onehot_decoder_seq_if.slave  bus
);

  localparam int OUT_W = 2 ** SEL_W;

  mode_e            mode;
  mode_e            mode_q;
  logic [SEL_W-1:0] idx_q, idx_d;
  logic [OUT_W-1:0] d_q, d_d;
  logic             ov_q, ov_d;
  logic             wrap_q, wrap_d;
  logic             vld_q, vld_d;
  logic             scanning;
  logic             restart;
  logic             tc;

  assign mode = mode_e'(bus.mode);

  assign scanning = bus.en & ((mode == MODE_UP) | (mode == MODE_DN));
  // mode_q only tracks enabled cycles, so a mode change made while disabled
  // still clears the counter once the block is re-enabled.
  assign restart  = bus.en & ((mode != mode_q) | (mode == MODE_DEC));

  dwell_timer #(.DWELL_W(DWELL_W)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .restart (restart),
    .run     (scanning),
    .dwell   (bus.dwell),
    .tc      (tc)
  );

  assign bus.in_ready = (mode == MODE_DEC) & bus.en;

  always_comb begin
    // NOTE: every output of this block gets a default first so no latch is inferred.
    idx_d  = idx_q;
    vld_d  = vld_q;
    wrap_d = 1'b0;
    d_d    = '0;
    ov_d   = 1'b0;
    if (bus.en) begin
      case (mode)
        MODE_DEC: begin
          if (bus.in_valid) begin
            idx_d = bus.I;
            vld_d = 1'b1;
          end
        end
        MODE_UP: begin
          vld_d = 1'b1;
          if (tc) begin
            idx_d  = idx_q + SEL_W'(1);
            wrap_d = (idx_q == {SEL_W{1'b1}});
          end
        end
        MODE_DN: begin
          vld_d = 1'b1;
          if (tc) begin
            idx_d  = idx_q - SEL_W'(1);
            wrap_d = (idx_q == '0);
          end
        end
        default: ;
      endcase
      // vld_q remembers that idx holds a real value, so D comes back after en returns.
      d_d  = vld_d ? OUT_W'(onehot(MAX_SEL_W'(idx_d))) : '0;
      ov_d = vld_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q <= MODE_DEC;
      idx_q  <= '0;
      d_q    <= '0;
      ov_q   <= 1'b0;
      wrap_q <= 1'b0;
      vld_q  <= 1'b0;
    end else begin
      if (bus.en) mode_q <= mode;
      idx_q  <= idx_d;
      d_q    <= d_d;
      ov_q   <= ov_d;
      wrap_q <= wrap_d;
      vld_q  <= vld_d;
    end
  end

  assign bus.D         = d_q;
  assign bus.idx       = idx_q;
  assign bus.out_valid = ov_q;
  assign bus.wrap      = wrap_q;

endmodule

// File: tb/tb_onehot_decoder_seq.sv
// Directed bench for onehot_decoder_seq: 4-output and 8-output instances.
module tb_onehot_decoder_seq;
  import decoder_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic rst3;
  int   vectors     = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  onehot_decoder_seq_if #(.SEL_W(2), .DWELL_W(4)) bus2 ();
  onehot_decoder_seq_if #(.SEL_W(3), .DWELL_W(4)) bus3 ();

  onehot_decoder_seq #(.SEL_W(2), .DWELL_W(4)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus2.slave)
  );

  onehot_decoder_seq #(.SEL_W(3), .DWELL_W(4)) u_dut3 (
    .clk (clk),
    .rst (rst3),
    .bus (bus3.slave)
  );

  // Observed output bundles {D, idx, out_valid, wrap}.
  wire [7:0]  obs2 = {bus2.D, bus2.idx, bus2.out_valid, bus2.wrap};
  wire [12:0] obs3 = {bus3.D, bus3.idx, bus3.out_valid, bus3.wrap};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst  = 1'b1;
    rst3 = 1'b1;
    repeat (2) begin
      bus2.mode     = 2'($urandom_range(3));
      bus2.en       = 1'($urandom_range(1));
      bus2.in_valid = 1'($urandom_range(1));
      bus2.I        = 2'($urandom_range(3));
      bus2.dwell    = 4'($urandom_range(15));
      bus3.mode     = 2'($urandom_range(3));
      bus3.en       = 1'($urandom_range(1));
      bus3.in_valid = 1'($urandom_range(1));
      bus3.I        = 3'($urandom_range(7));
      bus3.dwell    = 4'($urandom_range(15));
      tick();
    end
    vectors++;
    if (obs2 !== 8'b0000_00_0_0) begin
      miscompares++;
      $display("FAIL reset2 {D,idx,ov,wrap}: got %b expected %b", obs2, 8'b0000_00_0_0);
    end
    vectors++;
    if (obs3 !== 13'b00000000_000_0_0) begin
      miscompares++;
      $display("FAIL reset3 {D,idx,ov,wrap}: got %b expected %b", obs3, 13'b0);
    end
    bus2.mode = MODE_DEC; bus2.en = 1'b1; bus2.in_valid = 1'b0; bus2.I = '0; bus2.dwell = '0;
    bus3.mode = MODE_DEC; bus3.en = 1'b1; bus3.in_valid = 1'b0; bus3.I = '0; bus3.dwell = '0;
    #1;
    vectors++;
    if ({bus2.in_ready, bus3.in_ready} !== 2'b11) begin
      miscompares++;
      $display("FAIL reset_in_ready: got %b expected 11", {bus2.in_ready, bus3.in_ready});
    end
    rst  = 1'b0;
    rst3 = 1'b0;
  endtask

  task automatic test_decode_sweep();
    logic [7:0] exp_tab [4] = '{8'b0001_00_1_0, 8'b0010_01_1_0, 8'b0100_10_1_0, 8'b1000_11_1_0};
    for (int i = 0; i < 4; i++) begin
      bus2.in_valid = 1'b1;
      bus2.I        = 2'(i);
      tick();
      vectors++;
      if (obs2 !== exp_tab[i]) begin
        miscompares++;
        $display("FAIL decode[%0d] {D,idx,ov,wrap}: got %b expected %b", i, obs2, exp_tab[i]);
      end
    end
    bus2.in_valid = 1'b0;
    bus2.I        = 2'd1;
    repeat (2) begin
      tick();
      vectors++;
      if (obs2 !== 8'b1000_11_1_0) begin
        miscompares++;
        $display("FAIL decode_hold {D,idx,ov,wrap}: got %b expected %b", obs2, 8'b1000_11_1_0);
      end
    end
  endtask

  task automatic test_scan_up();
    logic [7:0] exp_tab [3] = '{8'b1000_11_1_0, 8'b0001_00_1_1, 8'b0010_01_1_0};
    bus2.in_valid = 1'b1;
    bus2.I        = 2'd2;
    tick();
    bus2.in_valid = 1'b0;
    bus2.mode     = MODE_UP;
    bus2.dwell    = 4'd0;
    #1;
    vectors++;
    if ({obs2, bus2.in_ready} !== 9'b0100_10_1_0_0) begin
      miscompares++;
      $display("FAIL scan_up_start {D,idx,ov,wrap,in_ready}: got %b expected %b", {obs2, bus2.in_ready}, 9'b0100_10_1_0_0);
    end
    for (int k = 0; k < 3; k++) begin
      tick();
      vectors++;
      if (obs2 !== exp_tab[k]) begin
        miscompares++;
        $display("FAIL scan_up[%0d] {D,idx,ov,wrap}: got %b expected %b", k, obs2, exp_tab[k]);
      end
    end
    bus2.mode     = MODE_DEC;
    bus2.in_valid = 1'b1;
    bus2.I        = 2'd0;
    tick();
    bus2.in_valid = 1'b0;
    vectors++;
    if (obs2 !== 8'b0001_00_1_0) begin
      miscompares++;
      $display("FAIL scan_exit {D,idx,ov,wrap}: got %b expected %b", obs2, 8'b0001_00_1_0);
    end
  endtask

  task automatic test_scan_down();
    logic [7:0] exp_tab [7] = '{8'b0001_00_1_0, 8'b0001_00_1_0, 8'b1000_11_1_1, 8'b1000_11_1_0,
                                8'b1000_11_1_0, 8'b0100_10_1_0, 8'b0100_10_1_0};
    bus2.mode     = MODE_DN;
    bus2.dwell    = 4'd2;
    bus2.in_valid = 1'b1;
    bus2.I        = 2'd3;
    #1;
    vectors++;
    if (bus2.in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL scan_dn_in_ready: got %b expected 0", bus2.in_ready);
    end
    for (int k = 0; k < 7; k++) begin
      tick();
      vectors++;
      if (obs2 !== exp_tab[k]) begin
        miscompares++;
        $display("FAIL scan_dn[%0d] {D,idx,ov,wrap}: got %b expected %b", k, obs2, exp_tab[k]);
      end
    end
    bus2.in_valid = 1'b0;
  endtask

  task automatic test_enable_gate();
    logic [7:0] exp_tab [10] = '{8'b0010_01_1_0, 8'b0010_01_1_0,
                                 8'b0000_01_0_0, 8'b0000_01_0_0, 8'b0000_01_0_0, 8'b0000_01_0_0,
                                 8'b0010_01_1_0, 8'b0100_10_1_0,
                                 8'b0100_10_1_0, 8'b0100_10_1_0};
    bus2.mode     = MODE_DEC;
    bus2.in_valid = 1'b1;
    bus2.I        = 2'd1;
    tick();
    bus2.in_valid = 1'b0;
    bus2.mode     = MODE_UP;
    bus2.dwell    = 4'd3;
    for (int k = 0; k < 10; k++) begin
      // Cycles 2..5 run disabled, cycles 8..9 run in HOLD.
      bus2.en = !(k >= 2 && k <= 5);
      if (k >= 8) bus2.mode = MODE_HOLD;
      tick();
      vectors++;
      if (obs2 !== exp_tab[k]) begin
        miscompares++;
        $display("FAIL en_gate[%0d] {D,idx,ov,wrap}: got %b expected %b", k, obs2, exp_tab[k]);
      end
    end
    bus2.mode = MODE_DEC;
    bus2.en   = 1'b0;
    #1;
    vectors++;
    if (bus2.in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL en_low_in_ready: got %b expected 0", bus2.in_ready);
    end
    bus2.en = 1'b1;
  endtask

  task automatic test_sel3();
    bus3.mode     = MODE_DEC;
    bus3.en       = 1'b1;
    bus3.in_valid = 1'b1;
    bus3.I        = 3'b101;
    tick();
    bus3.in_valid = 1'b0;
    vectors++;
    if (obs3 !== 13'b00100000_101_1_0) begin
      miscompares++;
      $display("FAIL sel3_decode {D,idx,ov,wrap}: got %b expected %b", obs3, 13'b00100000_101_1_0);
    end
    bus3.mode  = MODE_UP;
    bus3.dwell = 4'd4;
    repeat (2) begin
      tick();
      vectors++;
      if (obs3 !== 13'b00100000_101_1_0) begin
        miscompares++;
        $display("FAIL sel3_dwell {D,idx,ov,wrap}: got %b expected %b", obs3, 13'b00100000_101_1_0);
      end
    end
    rst3 = 1'b1;
    tick();
    vectors++;
    if (obs3 !== 13'b0) begin
      miscompares++;
      $display("FAIL sel3_mid_reset {D,idx,ov,wrap}: got %b expected %b", obs3, 13'b0);
    end
    rst3 = 1'b0;
    tick();
    vectors++;
    if (obs3 !== 13'b00000001_000_1_0) begin
      miscompares++;
      $display("FAIL sel3_rescan {D,idx,ov,wrap}: got %b expected %b", obs3, 13'b00000001_000_1_0);
    end
  endtask

  initial begin
    test_reset();
    test_decode_sweep();
    test_scan_up();
    test_scan_down();
    test_enable_gate();
    test_sel3();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
